// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: serialises one ALU command as strobed nibbles,
// waits the result latency, and returns the sampled result and flags.
module alu_cmd_sequencer #(
   parameter int          STROBE_LEN = 1,
   parameter int          GAP_LEN    = 1,
   parameter int          RESULT_LAT = 2,
   parameter logic [15:0] UNARY_MASK = 16'h0000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [3:0] cmd_opcode,
   input  logic [3:0] cmd_a,
   input  logic [3:0] cmd_b,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [3:0] rsp_result,
   output logic [3:0] rsp_flags,
   output logic       busy,
   output logic [3:0] alu_data,
   output logic       alu_process,
   input  logic [3:0] alu_result,
   input  logic [3:0] alu_flags
);
   localparam int MAXSG = STROBE_LEN > GAP_LEN ? STROBE_LEN : GAP_LEN;
   localparam int MAXL  = MAXSG > RESULT_LAT ? MAXSG : RESULT_LAT;
   localparam int CW    = $clog2(MAXL + 1);

   typedef enum logic [2:0] {IDLE, SEND, GAP, WAIT, RESP} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [1:0]    idx, idx_n;
   logic [3:0]    op, a, b, nib;
   logic          accept, last, sample;

   generate
      if (STROBE_LEN < 1 || GAP_LEN < 1 || RESULT_LAT < 1) begin : g_bad_cfg
         $error("alu_cmd_sequencer: STROBE_LEN, GAP_LEN and RESULT_LAT must be >= 1");
      end
   endgenerate

   assign cmd_ready   = (state == IDLE) & reset;
   assign accept      = cmd_valid & cmd_ready;
   assign nib         = idx == 2'd0 ? op : idx == 2'd1 ? a : b;
   assign last        = (idx == 2'd2) | ((idx == 2'd1) & UNARY_MASK[op]);
   assign sample      = (state == WAIT) & (cnt == '0);
   assign alu_process = state == SEND;
   assign alu_data    = alu_process ? nib : 4'h0;
   assign rsp_valid   = state == RESP;
   assign busy        = state != IDLE;

   // Counter reloads on every state entry and only counts down while nonzero.
   always_comb begin
      state_n = state;
      cnt_n   = cnt != '0 ? cnt - 1'b1 : cnt;
      idx_n   = idx;
      case (state)
         IDLE: if (accept) begin
            state_n = SEND;
            cnt_n   = CW'(STROBE_LEN - 1);
            idx_n   = 2'd0;
         end
         SEND: if (cnt == '0) begin
            state_n = last ? WAIT : GAP;
            cnt_n   = last ? CW'(RESULT_LAT - 1) : CW'(GAP_LEN - 1);
         end
         GAP: if (cnt == '0) begin
            state_n = SEND;
            cnt_n   = CW'(STROBE_LEN - 1);
            idx_n   = idx + 2'd1;
         end
         WAIT: if (cnt == '0) state_n = RESP;
         RESP: if (rsp_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= 2'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         idx   <= idx_n;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op <= 4'h0;
         a  <= 4'h0;
         b  <= 4'h0;
      end else if (accept) begin
         op <= cmd_opcode;
         a  <= cmd_a;
         b  <= cmd_b;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rsp_result <= 4'h0;
         rsp_flags  <= 4'h0;
      end else if (sample) begin
         rsp_result <= alu_result;
         rsp_flags  <= alu_flags;
      end
   end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed bench with a response scoreboard for the
// default/unary-mask configuration and a stretched-timing configuration.
module tb_alu_cmd_sequencer;
   logic       clk = 1'b0, reset = 1'b0, cmd_valid = 1'b0, cmd_valid2 = 1'b0, rsp_ready = 1'b0;
   logic [3:0] cmd_opcode = 4'h0, cmd_a = 4'h0, cmd_b = 4'h0, alu_result = 4'h0, alu_flags = 4'h0;
   logic       cmd_ready, rsp_valid, busy, alu_process;
   logic [3:0] rsp_result, rsp_flags, alu_data;
   logic       cmd_ready2, rsp_valid2, busy2, alu_process2;
   logic [3:0] rsp_result2, rsp_flags2, alu_data2;
   int         tests = 0, fails = 0;
   logic [7:0] sb[$];
   logic [4:0] tr[$];

   always #5 clk = ~clk;

   alu_cmd_sequencer #(.UNARY_MASK(16'h0004)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_flags(rsp_flags), .busy(busy), .alu_data(alu_data),
      .alu_process(alu_process), .alu_result(alu_result), .alu_flags(alu_flags)
   );

   alu_cmd_sequencer #(.STROBE_LEN(2), .GAP_LEN(3), .RESULT_LAT(4)) dut2 (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
      .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_result(rsp_result2),
      .rsp_flags(rsp_flags2), .busy(busy2), .alu_data(alu_data2),
      .alu_process(alu_process2), .alu_result(alu_result), .alu_flags(alu_flags)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Handshake in cycle 0, then scramble cmd_* to prove they are not re-read.
   task automatic send(input bit d2, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b, input bit push);
      cmd_opcode = op;
      cmd_a      = a;
      cmd_b      = b;
      chk("cmd_ready_before", d2 ? cmd_ready2 : cmd_ready, 8'h1);
      if (d2) cmd_valid2 = 1'b1; else cmd_valid = 1'b1;
      if (push) sb.push_back({alu_result, alu_flags});
      tick;
      cmd_valid  = 1'b0;
      cmd_valid2 = 1'b0;
      cmd_opcode = ~op;
      cmd_a      = ~a;
      cmd_b      = ~b;
   endtask

   task automatic run_trace(input bit d2);
      foreach (tr[i]) begin
         chk("process", d2 ? alu_process2 : alu_process, {7'h0, tr[i][4]});
         chk("data", d2 ? alu_data2 : alu_data, {4'h0, tr[i][3:0]});
         chk("rsp_valid_early", d2 ? rsp_valid2 : rsp_valid, 8'h0);
         tick;
      end
      chk("rsp_valid_at_latency", d2 ? rsp_valid2 : rsp_valid, 8'h1);
   endtask

   task automatic await_rsp(input bit d2, input int exp_lat);
      int n = 1;
      while (!(d2 ? rsp_valid2 : rsp_valid) && n < 200) begin
         tick;
         n++;
      end
      chk("latency", n[7:0], exp_lat[7:0]);
   endtask

   task automatic take_rsp(input bit d2);
      logic [7:0] e;
      e = sb.size() != 0 ? sb.pop_front() : 8'hxx;
      chk("rsp_data", d2 ? {rsp_result2, rsp_flags2} : {rsp_result, rsp_flags}, e);
      rsp_ready = 1'b1;
      tick;
      rsp_ready = 1'b0;
      chk("rsp_valid_drop", d2 ? rsp_valid2 : rsp_valid, 8'h0);
      chk("cmd_ready_after", d2 ? cmd_ready2 : cmd_ready, 8'h1);
   endtask

   initial begin
      repeat (2) tick;
      chk("rst_cmd_ready", cmd_ready, 8'h0);
      chk("rst_busy", busy, 8'h0);
      chk("rst_rsp_valid", rsp_valid, 8'h0);
      chk("rst_process", alu_process, 8'h0);
      chk("rst_data", alu_data, 8'h0);
      chk("rst_rsp", {rsp_result, rsp_flags}, 8'h00);
      reset = 1'b1;
      tick;
      chk("rel_cmd_ready", cmd_ready, 8'h1);
      chk("rel_busy", busy, 8'h0);
      chk("rel_rsp_valid", rsp_valid, 8'h0);

      // Binary command, inputs scrambled after acceptance
      alu_result = 4'h8;
      alu_flags  = 4'h2;
      tr = '{5'h11, 5'h00, 5'h15, 5'h00, 5'h13, 5'h00, 5'h00};
      send(1'b0, 4'h1, 4'h5, 4'h3, 1'b1);
      chk("busy_in_flight", busy, 8'h1);
      run_trace(1'b0);
      take_rsp(1'b0);

      // Unary opcode 2: two strobes only
      alu_result = 4'h6;
      alu_flags  = 4'h4;
      tr = '{5'h12, 5'h00, 5'h1A, 5'h00, 5'h00};
      send(1'b0, 4'h2, 4'hA, 4'h7, 1'b1);
      run_trace(1'b0);
      take_rsp(1'b0);

      // Response backpressure
      alu_result = 4'hC;
      alu_flags  = 4'h1;
      send(1'b0, 4'h3, 4'h1, 4'h2, 1'b1);
      await_rsp(1'b0, 8);
      alu_result = 4'h0;
      alu_flags  = 4'h0;
      cmd_valid  = 1'b1;
      repeat (10) begin
         chk("hold_valid", rsp_valid, 8'h1);
         chk("hold_data", {rsp_result, rsp_flags}, sb.size() != 0 ? sb[0] : 8'hxx);
         chk("hold_cmd_ready", cmd_ready, 8'h0);
         tick;
      end
      cmd_valid = 1'b0;
      take_rsp(1'b0);

      // Asynchronous reset during the A strobe
      alu_result = 4'h3;
      send(1'b0, 4'h1, 4'h6, 4'h7, 1'b0);
      tick;
      tick;
      chk("pre_reset_process", alu_process, 8'h1);
      chk("pre_reset_data", alu_data, 8'h6);
      #2 reset = 1'b0;
      #1;
      chk("async_process", alu_process, 8'h0);
      chk("async_data", alu_data, 8'h0);
      chk("async_busy", busy, 8'h0);
      tick;
      reset = 1'b1;
      tick;
      repeat (12) begin
         chk("no_orphan_rsp", rsp_valid, 8'h0);
         tick;
      end
      alu_result = 4'h9;
      alu_flags  = 4'h5;
      send(1'b0, 4'h4, 4'h9, 4'h9, 1'b1);
      await_rsp(1'b0, 8);
      take_rsp(1'b0);

      // Stretched timing: strobe 2, gap 3, latency 4
      alu_result = 4'h5;
      alu_flags  = 4'h3;
      tr = {};
      repeat (2) tr.push_back(5'h17);
      repeat (3) tr.push_back(5'h00);
      repeat (2) tr.push_back(5'h12);
      repeat (3) tr.push_back(5'h00);
      repeat (2) tr.push_back(5'h19);
      repeat (4) tr.push_back(5'h00);
      send(1'b1, 4'h7, 4'h2, 4'h9, 1'b1);
      run_trace(1'b1);
      alu_result = 4'hE;
      alu_flags  = 4'hF;
      tick;
      take_rsp(1'b1);

      chk("sb_drained", sb.size() > 255 ? 8'hFF : 8'(sb.size()), 8'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Host-side initiator for the 4-bit sequential ALU's nibble-serial command interface.
- Accepts one ALU command per valid/ready handshake: opcode plus one or two operands.
- Serialises the command as nibbles on alu_data, each qualified by an alu_process strobe, waits a fixed result latency, then captures alu_result and alu_flags.
- Returns the captured result and flags to the host through a valid/ready response channel. Sits between the system command source and the ALU's io_in/io_out pins.

Parameters:
- STROBE_LEN, 1: cycles alu_process is held high per nibble (legal range ≥1).
- GAP_LEN, 1: cycles alu_process is held low between nibbles (legal range ≥1).
- RESULT_LAT, 2: cycles from the last strobe cycle to the result sample point (legal range ≥1).
- UNARY_MASK, 16'h0000: bit k set means opcode k is unary, so operand B is not sent.

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-low reset. Asserted = 0.
- cmd_valid, input, 1: host command valid.
- cmd_ready, output, 1: sequencer can accept a command.
- cmd_opcode, input, 4: ALU opcode.
- cmd_a, input, 4: operand A.
- cmd_b, input, 4: operand B; ignored for unary opcodes.
- rsp_valid, output, 1: response valid.
- rsp_ready, input, 1: host accepts response.
- rsp_result, output, 4: captured alu_result.
- rsp_flags, output, 4: captured alu_flags.
- busy, output, 1: a transaction is in flight (state is not IDLE).
- alu_data, output, 4: nibble driven to the ALU data pins.
- alu_process, output, 1: ALU process strobe.
- alu_result, input, 4: ALU result pins.
- alu_flags, input, 4: ALU flag pins.

Behaviour:
- Reset values while reset=0: state IDLE; alu_process=0, alu_data=0, rsp_valid=0, rsp_result=0, rsp_flags=0, busy=0, cmd_ready=0.
- Reset acts immediately, including mid-transaction. Any partial nibble sequence is abandoned and no response is produced.
- cmd_ready = (state==IDLE) & reset. It is therefore 1 in the first cycle after reset release.
- States:
  - IDLE → SEND on the handshake cmd_valid & cmd_ready. opcode, A and B are registered at that edge; later changes to cmd_* are ignored.
  - SEND: alu_process=1 and alu_data = the current nibble, for STROBE_LEN cycles. Nibble order is opcode, A, then B.
  - SEND → GAP if more nibbles remain.
  - SEND → WAIT after the last nibble. The last nibble is A if UNARY_MASK[opcode]=1, otherwise B.
  - GAP: alu_process=0 and alu_data=0 for GAP_LEN cycles, then → SEND with the next nibble.
  - WAIT: alu_process=0 and alu_data=0. alu_result and alu_flags are registered at the clock edge ending the RESULT_LAT-th cycle after the last strobe cycle, then → RESP.
  - RESP: rsp_valid=1. rsp_result and rsp_flags are held stable until rsp_valid & rsp_ready. On that handshake → IDLE and rsp_valid drops the next cycle.
- Latency with defaults (handshake at the edge ending cycle 0):
  - Binary op: strobes in cycles 1 (opcode), 3 (A) and 5 (B); gaps in cycles 2 and 4; sample at the end of cycle 7; rsp_valid from cycle 8.
  - Unary op: strobes in cycles 1 and 3; sample at the end of cycle 5; rsp_valid from cycle 6.
- General latency, handshake to first rsp_valid cycle: N·STROBE_LEN + (N−1)·GAP_LEN + RESULT_LAT + 1, where N = 3 for binary and N = 2 for unary.
- Only one transaction is ever outstanding. No new command is accepted while in RESP, even if rsp_ready is held high. A back-to-back command is accepted at the earliest in the cycle after the response handshake.
- All counters are sized for their parameter and saturate-free. Each counter reloads on every state entry and never wraps mid-state.
- alu_process is never high outside SEND. alu_data is 0 whenever alu_process is 0.
- Parameter values outside their legal range are a configuration error and are flagged by an elaboration-time check.

Test Plan:
1. Reset release → cmd_ready=1, busy=0, rsp_valid=0. Binary command opcode=4'h1, A=4'h5, B=4'h3 with defaults → alu_data/alu_process trace 1/1, 0/0, 5/1, 0/0, 3/1, 0/0, 0/0. With alu_result=4'h8 and alu_flags=4'h2 stable → rsp_result=8, rsp_flags=2, rsp_valid in cycle 8.
2. UNARY_MASK=16'h0004, opcode=4'h2, A=4'hA → exactly two strobes (2 then A), B never driven, rsp_valid in cycle 6.
3. Response backpressure: rsp_ready=0 for 10 cycles → rsp_valid and rsp_result held stable, cmd_ready=0 throughout even with cmd_valid=1. Raise rsp_ready → one handshake, then cmd_ready=1 the next cycle.
4. Drive reset=0 asynchronously during the second strobe (A) → alu_process=0, alu_data=0 and busy=0 immediately. After release, no rsp_valid appears and a new command completes normally.
5. STROBE_LEN=2, GAP_LEN=3, RESULT_LAT=4, binary op → each strobe lasts 2 cycles and each gap 3 cycles; rsp_valid at cycle 3·2+2·3+4+1=17. The result is sampled from the value present at the end of cycle 16; the bench changes alu_result in cycle 17 to prove it is not re-sampled.
6. Changing cmd_opcode, cmd_a and cmd_b after the handshake → the serialised nibbles match the values at acceptance.
